control_unit_fsm: RTL

//  Multicycle controller that sequences the MIPS-subset datapath: PC, MEM, IR, register bank, A/B, ALU, ALUOut, MDR, EPC.

---
 rtl/control_unit_fsm_if.sv | 40 ++++
 rtl/control_unit_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm_if.sv
// Control bundle between the multicycle controller and the MIPS-subset datapath.
// The controller takes the master side; the datapath takes the slave side.
interface control_unit_fsm_if;
  logic [5:0]  OPCODE;
  logic [5:0]  FUNCT;
  logic        O;
  logic        ET;
  logic        PC_w;
  logic        MEM_w;
  logic        IR_w;
  logic        REG_w;
  logic        AB_w;
  logic        EPC_w;
  logic        MDR_w;
  logic        ALUOut_w;
  logic [2:0]  ALU_op;
  logic [1:0]  M_SrcA;
  logic [1:0]  M_SrcB;
  logic [1:0]  M_RMEM;
  logic [1:0]  M_EXCEPTION;
  logic [1:0]  M_PC;
  logic [1:0]  M_WRITE_REG;
  logic [1:0]  M_WRITE_DATA;
  // Constant fed to the register-bank write mux when M_WRITE_DATA selects the stack init value
  logic [31:0] SP_VALUE;

  modport master (
    input  OPCODE, FUNCT, O, ET,
    output PC_w, MEM_w, IR_w, REG_w, AB_w, EPC_w, MDR_w, ALUOut_w,
    output ALU_op, M_SrcA, M_SrcB, M_RMEM, M_EXCEPTION, M_PC,
    output M_WRITE_REG, M_WRITE_DATA, SP_VALUE
  );

  modport slave (
    output OPCODE, FUNCT, O, ET,
    input  PC_w, MEM_w, IR_w, REG_w, AB_w, EPC_w, MDR_w, ALUOut_w,
    input  ALU_op, M_SrcA, M_SrcB, M_RMEM, M_EXCEPTION, M_PC,
    input  M_WRITE_REG, M_WRITE_DATA, SP_VALUE
  );
endinterface

// File: rtl/control_unit_fsm.sv
// Multicycle MIPS-subset controller: one state per datapath step, with memory
// wait cycles, stack-pointer initialisation and bad-opcode/overflow exceptions.
module control_unit_fsm #(
  parameter int MEM_WAIT = 2,
  parameter int SP_INIT  = 227
) (
  input  logic                 clk,
  input  logic                 reset,
  control_unit_fsm_if.master   bus,
  output logic [4:0]           state_o
);

  localparam int CNT_W = $clog2(MEM_WAIT + 1);

  localparam logic [4:0] S_RESET     = 5'd0;
  localparam logic [4:0] S_FETCH     = 5'd1;
  localparam logic [4:0] S_DECODE    = 5'd2;
  localparam logic [4:0] S_R_EXEC    = 5'd3;
  localparam logic [4:0] S_R_WB      = 5'd4;
  localparam logic [4:0] S_ADDI_EXEC = 5'd5;
  localparam logic [4:0] S_I_WB      = 5'd6;
  localparam logic [4:0] S_MEM_ADDR  = 5'd7;
  localparam logic [4:0] S_LW_READ   = 5'd8;
  localparam logic [4:0] S_LW_WB     = 5'd9;
  localparam logic [4:0] S_SW_WRITE  = 5'd10;
  localparam logic [4:0] S_BEQ       = 5'd11;
  localparam logic [4:0] S_J         = 5'd12;
  localparam logic [4:0] S_EXC_EPC   = 5'd13;
  localparam logic [4:0] S_EXC_READ  = 5'd14;
  localparam logic [4:0] S_EXC_JUMP  = 5'd15;

  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             wait_last;
  logic             wait_state;

  assign wait_last    = (cnt_q == CNT_W'(MEM_WAIT - 1));
  assign wait_state   = (state_q == S_FETCH) || (state_q == S_LW_READ) || (state_q == S_EXC_READ);
  assign state_o      = state_q;
  assign bus.SP_VALUE = 32'(SP_INIT);

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    bus.PC_w         = 1'b0;
    bus.MEM_w        = 1'b0;
    bus.IR_w         = 1'b0;
    bus.REG_w        = 1'b0;
    bus.AB_w         = 1'b0;
    bus.EPC_w        = 1'b0;
    bus.MDR_w        = 1'b0;
    bus.ALUOut_w     = 1'b0;
    bus.ALU_op       = 3'b000;
    bus.M_SrcA       = 2'b00;
    bus.M_SrcB       = 2'b00;
    bus.M_RMEM       = 2'b00;
    bus.M_EXCEPTION  = 2'b00;
    bus.M_PC         = 2'b00;
    bus.M_WRITE_REG  = 2'b00;
    bus.M_WRITE_DATA = 2'b00;
    // Reset masks every output so an interrupted instruction leaves no partial write.
    if (!reset) begin
      case (state_q)
        S_RESET: begin
          bus.REG_w        = 1'b1;
          bus.M_WRITE_REG  = 2'b10;
          bus.M_WRITE_DATA = 2'b10;
          state_d          = S_FETCH;
        end
        S_FETCH: begin
          bus.M_SrcB = 2'b01;
          bus.ALU_op = 3'b001;
          if (wait_last) begin
            bus.IR_w = 1'b1;
            bus.PC_w = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.AB_w     = 1'b1;
          bus.ALUOut_w = 1'b1;
          bus.M_SrcB   = 2'b11;
          bus.ALU_op   = 3'b001;
          case (bus.OPCODE)
            6'h00:        state_d = S_R_EXEC;
            6'h08:        state_d = S_ADDI_EXEC;
            6'h23, 6'h2b: state_d = S_MEM_ADDR;
            6'h04:        state_d = S_BEQ;
            6'h02:        state_d = S_J;
            default: begin
              state_d = S_EXC_EPC;
              cause_d = 2'b00;
            end
          endcase
        end
        S_R_EXEC: begin
          bus.M_SrcA = 2'b01;
          case (bus.FUNCT)
            6'h20, 6'h22: begin
              bus.ALU_op   = (bus.FUNCT == 6'h20) ? 3'b001 : 3'b010;
              bus.ALUOut_w = 1'b1;
              if (bus.O) begin
                state_d = S_EXC_EPC;
                cause_d = 2'b01;
              end else begin
                state_d = S_R_WB;
              end
            end
            6'h24: begin
              bus.ALU_op   = 3'b011;
              bus.ALUOut_w = 1'b1;
              state_d      = S_R_WB;
            end
            default: begin
              state_d = S_EXC_EPC;
              cause_d = 2'b00;
            end
          endcase
        end
        S_R_WB: begin
          bus.REG_w       = 1'b1;
          bus.M_WRITE_REG = 2'b01;
          state_d         = S_FETCH;
        end
        S_ADDI_EXEC: begin
          bus.M_SrcA   = 2'b01;
          bus.M_SrcB   = 2'b10;
          bus.ALU_op   = 3'b001;
          bus.ALUOut_w = 1'b1;
          if (bus.O) begin
            state_d = S_EXC_EPC;
            cause_d = 2'b01;
          end else begin
            state_d = S_I_WB;
          end
        end
        S_I_WB: begin
          bus.REG_w = 1'b1;
          state_d   = S_FETCH;
        end
        S_MEM_ADDR: begin
          bus.M_SrcA   = 2'b01;
          bus.M_SrcB   = 2'b10;
          bus.ALU_op   = 3'b001;
          bus.ALUOut_w = 1'b1;
          state_d      = (bus.OPCODE == 6'h2b) ? S_SW_WRITE : S_LW_READ;
        end
        S_LW_READ: begin
          bus.M_RMEM = 2'b01;
          if (wait_last) begin
            bus.MDR_w = 1'b1;
            state_d   = S_LW_WB;
          end
        end
        S_LW_WB: begin
          bus.REG_w        = 1'b1;
          bus.M_WRITE_DATA = 2'b01;
          state_d          = S_FETCH;
        end
        S_SW_WRITE: begin
          bus.M_RMEM = 2'b01;
          bus.MEM_w  = 1'b1;
          state_d    = S_FETCH;
        end
        S_BEQ: begin
          bus.M_SrcA = 2'b01;
          bus.ALU_op = 3'b111;
          if (bus.ET) begin
            bus.PC_w = 1'b1;
            bus.M_PC = 2'b01;
          end
          state_d = S_FETCH;
        end
        S_J: begin
          bus.PC_w = 1'b1;
          bus.M_PC = 2'b10;
          state_d  = S_FETCH;
        end
        S_EXC_EPC: begin
          bus.M_SrcB = 2'b01;
          bus.ALU_op = 3'b010;
          bus.EPC_w  = 1'b1;
          state_d    = S_EXC_READ;
        end
        S_EXC_READ: begin
          bus.M_RMEM      = 2'b10;
          bus.M_EXCEPTION = cause_q;
          if (wait_last) begin
            bus.MDR_w = 1'b1;
            state_d   = S_EXC_JUMP;
          end
        end
        S_EXC_JUMP: begin
          bus.PC_w = 1'b1;
          bus.M_PC = 2'b11;
          state_d  = S_FETCH;
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  // Wait counter restarts on every state change and stops at its last value.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_state && !wait_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule
